wb_host_arbiter: RTL and testbench

Two-master Wishbone classic arbiter in front of the Azadi SoC's single host bus port in the Caravel user area. Master 0 is the management SoC Wishbone slave port (wbs_*); master 1 is the logic-analyzer-driven debug master. The block grants the downstream port round-robin, holds the grant for one complete transfer, and, when enabled, terminates transfers that hang.

---
 rtl/wb_host_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_wb_host_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_host_arbiter.sv
// Two-master Wishbone classic round-robin arbiter for the single host bus port.
// Optional hung-transfer termination is compiled in with WB_ARB_TIMEOUT_EN.
module wb_host_arbiter #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [3:0]    m0_sel_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [3:0]    m1_sel_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [3:0]    s_sel_o,
  output logic [AW-1:0] s_adr_o,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o,
  input  logic          timeout_clr_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_r;
  state_t state_s;
  logic   last_r;
  logic   last_s;
  logic   m0_req_s;
  logic   m1_req_s;
  logic   own_cyc_s;
  logic   fire_s;

  assign m0_req_s = m0_cyc_i & m0_stb_i;
  assign m1_req_s = m1_cyc_i & m1_stb_i;

  // Cycle line of whichever master currently owns the bus
  always_comb begin
    own_cyc_s = 1'b0;
    case (state_r)
      GNT0:    own_cyc_s = m0_cyc_i;
      GNT1:    own_cyc_s = m1_cyc_i;
      default: own_cyc_s = 1'b0;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt_r;
  logic          tmo_r;

  // A slave ack in the terminal cycle wins over the forced error completion
  assign fire_s = (state_r != IDLE) && (cnt_r == CW'(TIMEOUT)) && !s_ack_i && own_cyc_s;

  // Wait counter: held at zero while idle so every grant starts from zero
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == IDLE) begin
      cnt_r <= {CW{1'b0}};
    end else if (!s_ack_i) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_r <= 1'b0;
    end else if (fire_s) begin
      tmo_r <= 1'b1;
    end else if (timeout_clr_i) begin
      tmo_r <= 1'b0;
    end else begin
      tmo_r <= tmo_r;
    end
  end

  assign timeout_o = tmo_r;
`else
  localparam int unused_timeout_p = TIMEOUT;
  logic          unused_clr_s;

  assign unused_clr_s = timeout_clr_i;
  assign fire_s       = 1'b0;
  assign timeout_o    = 1'b0;
`endif

  // Grant state and last-served pointer (m0 wins the first tie after reset)
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
    end
  end

  // Round-robin arbitration and end-of-transfer detection
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    case (state_r)
      IDLE: begin
        if (m0_req_s && (!m1_req_s || last_r)) begin
          state_s = GNT0;
          last_s  = 1'b0;
        end else if (m1_req_s) begin
          state_s = GNT1;
          last_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      GNT0: begin
        if (s_ack_i || !m0_cyc_i || fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = GNT0;
        end
      end
      GNT1: begin
        if (s_ack_i || !m1_cyc_i || fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = GNT1;
        end
      end
      default: begin
        state_s = IDLE;
        last_s  = 1'b1;
      end
    endcase
  end

  // Bus steering: owner drives the slave port, only the owner sees the response
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 4'h0;
    s_adr_o  = {AW{1'b0}};
    s_dat_o  = {DW{1'b0}};
    m0_ack_o = 1'b0;
    m0_dat_o = {DW{1'b0}};
    m1_ack_o = 1'b0;
    m1_dat_o = {DW{1'b0}};
    grant_o  = 2'b00;
    case (state_r)
      GNT0: begin
        s_cyc_o  = m0_cyc_i & ~fire_s;
        s_stb_o  = m0_stb_i & ~fire_s;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i | fire_s;
        m0_dat_o = fire_s ? ERR_DATA : s_dat_i;
        grant_o  = 2'b01;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i & ~fire_s;
        s_stb_o  = m1_stb_i & ~fire_s;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i | fire_s;
        m1_dat_o = fire_s ? ERR_DATA : s_dat_i;
        grant_o  = 2'b10;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_host_arbiter.sv
// Self-checking bench for wb_host_arbiter: directed scenarios plus a randomized
// run against a transaction-level arbitration model.
module tb_wb_host_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack;
  logic [1:0]  grant;
  logic        tmo, tmo_clr;
  logic [139:0] outs;

  int checks = 0;
  int failures = 0;

  wb_host_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(tmo), .timeout_clr_i(tmo_clr)
  );

  assign outs = {s_cyc, s_stb, s_we, s_sel, s_adr, s_wdat,
                 m0_ack, m0_rdat, m1_ack, m1_rdat, grant, tmo};

  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = 32'h0; m0_wdat = 32'h0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = 32'h0; m1_wdat = 32'h0;
    s_ack = 1'b0; s_rdat = 32'h0; tmo_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if (outs !== 140'd0) begin failures++; $display("FAIL reset_outs: got %h expected 0", outs); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (outs !== 140'd0) begin failures++; $display("FAIL post_reset_idle: got %h expected 0", outs); end
    step();
  endtask

  task automatic test_single_read();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = 32'h3000_0004;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || s_stb !== 1'b0) begin failures++; $display("FAIL rd_arb_cycle: grant=%b stb=%b expected 00/0", grant, s_stb); end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || s_stb !== 1'b1 || s_adr !== 32'h3000_0004) begin
      failures++; $display("FAIL rd_granted: grant=%b stb=%b adr=%h expected 01/1/30000004", grant, s_stb, s_adr);
    end
    step();
    s_ack = 1'b1; s_rdat = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || m0_rdat !== 32'h1234_5678) begin
      failures++; $display("FAIL rd_data: ack=%b dat=%h expected 1/12345678", m0_ack, m0_rdat);
    end
    checks++;
    if (m1_ack !== 1'b0 || m1_rdat !== 32'h0) begin failures++; $display("FAIL rd_m1_quiet: ack=%b dat=%h expected 0/0", m1_ack, m1_rdat); end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL rd_release: grant=%b expected 00", grant); end
    step();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    pulse_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    s_ack = 1'b1; s_rdat = $urandom;
    for (int i = 0; i < 8; i++) begin
      exp_g = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
      @(negedge clk);
      checks++;
      if (grant !== exp_g || m0_ack !== exp_g[0] || m1_ack !== exp_g[1]) begin
        failures++; $display("FAIL rr_seq[%0d]: grant=%b acks=%b%b expected %b", i, grant, m1_ack, m0_ack, exp_g);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_m1_write();
    logic [31:0] adr;
    adr = $urandom;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'b0011; m1_adr = adr; m1_wdat = 32'hA5A5_A5A5;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL wr_arb_cycle: grant=%b expected 00", grant); end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (grant !== 2'b10 || s_we !== 1'b1 || s_sel !== 4'b0011 || s_wdat !== 32'hA5A5_A5A5 || s_adr !== adr) begin
        failures++; $display("FAIL wr_pass[%0d]: grant=%b we=%b sel=%b dat=%h adr=%h expected 10/1/0011/a5a5a5a5/%h",
                             i, grant, s_we, s_sel, s_wdat, s_adr, adr);
      end
    end
    step();
    s_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin failures++; $display("FAIL wr_ack: m1=%b m0=%b expected 1/0", m1_ack, m0_ack); end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_abort();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || s_cyc !== 1'b1) begin failures++; $display("FAIL ab_grant0: grant=%b cyc=%b expected 01/1", grant, s_cyc); end
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (s_cyc !== 1'b0 || grant !== 2'b01) begin failures++; $display("FAIL ab_cyc_drop: cyc=%b grant=%b expected 0/01", s_cyc, grant); end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL ab_idle: grant=%b expected 00", grant); end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || s_cyc !== 1'b1) begin failures++; $display("FAIL ab_grant1: grant=%b cyc=%b expected 10/1", grant, s_cyc); end
    step();
    s_ack = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_sel = 4'hF; m0_adr = 32'h3000_0010;
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || m0_ack !== 1'b0) begin failures++; $display("FAIL to_grant: grant=%b ack=%b expected 01/0", grant, m0_ack); end
    for (int k = 1; k < 16; k++) begin
      step();
      @(negedge clk);
      checks++;
      if (m0_ack !== 1'b0 || s_cyc !== 1'b1) begin failures++; $display("FAIL to_wait[%0d]: ack=%b cyc=%b expected 0/1", k, m0_ack, s_cyc); end
    end
    step();
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b1 || m0_rdat !== ERR || s_cyc !== 1'b0 || s_stb !== 1'b0 || tmo !== 1'b0) begin
      failures++; $display("FAIL to_fire: ack=%b dat=%h cyc=%b stb=%b flag=%b expected 1/deadbeef/0/0/0", m0_ack, m0_rdat, s_cyc, s_stb, tmo);
    end
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (tmo !== 1'b1 || grant !== 2'b00) begin failures++; $display("FAIL to_flag: flag=%b grant=%b expected 1/00", tmo, grant); end
    step(); step();
    tmo_clr = 1'b1;
    @(negedge clk);
    checks++;
    if (tmo !== 1'b1) begin failures++; $display("FAIL to_sticky: flag=%b expected 1", tmo); end
    step();
    tmo_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (tmo !== 1'b0) begin failures++; $display("FAIL to_clear: flag=%b expected 0", tmo); end
    step();
  endtask
`endif

  task automatic test_async_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_wdat = 32'h0BAD_F00D;
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b10 || s_cyc !== 1'b1) begin failures++; $display("FAIL ar_in_gnt1: grant=%b cyc=%b expected 10/1", grant, s_cyc); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 140'd0) begin failures++; $display("FAIL ar_async_zero: got %h expected 0", outs); end
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b00) begin failures++; $display("FAIL ar_idle_after: grant=%b expected 00", grant); end
    step();
    @(negedge clk);
    checks++;
    if (grant !== 2'b01) begin failures++; $display("FAIL ar_m0_first: grant=%b expected 01", grant); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_random();
    logic        mc[2], ms[2], mw[2];
    logic [3:0]  msel[2];
    logic [31:0] madr[2], mdat[2];
    logic        ackd[2];
    int          owner, last, cnt, k;
    bit          flag, fire, r0, r1;
    logic        e_cyc, e_stb, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat;
    logic [1:0]  e_ack, e_g;
    logic [31:0] e_md[2];
    logic [139:0] exp_v;
    idle_inputs();
    pulse_reset();
    owner = 0; last = 1; cnt = 0; flag = 1'b0;
    for (int m = 0; m < 2; m++) begin
      mc[m] = 1'b0; ms[m] = 1'b0; mw[m] = 1'b0; msel[m] = 4'h0; madr[m] = 32'h0; mdat[m] = 32'h0; ackd[m] = 1'b0;
    end
    for (int cyc_n = 0; cyc_n < 2000; cyc_n++) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (mc[m]) begin
          if (ackd[m] || $urandom_range(19) == 0) begin mc[m] = 1'b0; ms[m] = 1'b0; end
        end else if ($urandom_range(2) == 0) begin
          mc[m] = 1'b1; ms[m] = 1'b1; mw[m] = 1'($urandom);
          msel[m] = 4'($urandom); madr[m] = $urandom; mdat[m] = $urandom;
        end
      end
      m0_cyc = mc[0]; m0_stb = ms[0]; m0_we = mw[0]; m0_sel = msel[0]; m0_adr = madr[0]; m0_wdat = mdat[0];
      m1_cyc = mc[1]; m1_stb = ms[1]; m1_we = mw[1]; m1_sel = msel[1]; m1_adr = madr[1]; m1_wdat = mdat[1];
      s_ack = 1'($urandom_range(1)); s_rdat = $urandom; tmo_clr = ($urandom_range(7) == 0);
      @(negedge clk);
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_adr = 32'h0; e_dat = 32'h0;
      e_ack = 2'b00; e_g = 2'b00; e_md[0] = 32'h0; e_md[1] = 32'h0;
      k = (owner == 2) ? 1 : 0;
      fire = TMO_EN && owner != 0 && cnt == TMO && !s_ack && mc[k];
      if (owner != 0) begin
        e_cyc = mc[k] & ~fire; e_stb = ms[k] & ~fire; e_we = mw[k];
        e_sel = msel[k]; e_adr = madr[k]; e_dat = mdat[k];
        e_ack[k] = s_ack | fire;
        e_md[k] = fire ? ERR : s_rdat;
        e_g[k] = 1'b1;
      end
      exp_v = {e_cyc, e_stb, e_we, e_sel, e_adr, e_dat, e_ack[0], e_md[0], e_ack[1], e_md[1], e_g, flag};
      checks++;
      if (outs !== exp_v) begin failures++; $display("FAIL rand[%0d]: got %h expected %h", cyc_n, outs, exp_v); end
      ackd[0] = e_ack[0]; ackd[1] = e_ack[1];
      if (owner == 0) begin
        r0 = mc[0] & ms[0]; r1 = mc[1] & ms[1];
        if (r0 && r1) owner = (last == 1) ? 1 : 2;
        else if (r0) owner = 1;
        else if (r1) owner = 2;
        if (owner != 0) begin last = owner - 1; cnt = 0; end
      end else if (s_ack || !mc[k] || fire) begin
        owner = 0;
      end else begin
        cnt++;
      end
      if (fire) flag = 1'b1;
      else if (tmo_clr) flag = 1'b0;
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_m1_write();
    test_abort();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
